// File: rtl/move_codes_pkg.sv
// Shared move-code definitions for the solver, the move sequencer and the
// stepper sequencer.
// Contents:
//   MV_* constants   4-bit move codes (0/1 no-op, 2..13 face turns, 14/15 illegal)
//   face_t           face indices RIGHT..DOWN
//   seq_state_t      move_sequencer FSM state, also exported on its debug port
//   is_legal_move()  true for codes 2..13
//   is_nop()         true for codes 0/1
//   face_of()        face index of a legal move code
package move_codes_pkg;

  localparam logic [3:0] MV_NOP0 = 4'd0;
  localparam logic [3:0] MV_NOP1 = 4'd1;
  localparam logic [3:0] MV_R    = 4'd2;
  localparam logic [3:0] MV_RI   = 4'd3;
  localparam logic [3:0] MV_U    = 4'd4;
  localparam logic [3:0] MV_UI   = 4'd5;
  localparam logic [3:0] MV_F    = 4'd6;
  localparam logic [3:0] MV_FI   = 4'd7;
  localparam logic [3:0] MV_L    = 4'd8;
  localparam logic [3:0] MV_LI   = 4'd9;
  localparam logic [3:0] MV_B    = 4'd10;
  localparam logic [3:0] MV_BI   = 4'd11;
  localparam logic [3:0] MV_D    = 4'd12;
  localparam logic [3:0] MV_DI   = 4'd13;

  typedef enum logic [2:0] {
    FACE_RIGHT = 3'd0,
    FACE_UP    = 3'd1,
    FACE_FRONT = 3'd2,
    FACE_LEFT  = 3'd3,
    FACE_BACK  = 3'd4,
    FACE_DOWN  = 3'd5
  } face_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } seq_state_t;

  function automatic logic is_legal_move(input logic [3:0] code);
    return (code >= MV_R) && (code <= MV_DI);
  endfunction

  function automatic logic is_nop(input logic [3:0] code);
    return (code == MV_NOP0) || (code == MV_NOP1);
  endfunction

  // Codes come in (clockwise, counter-clockwise) pairs per face, starting at R.
  function automatic face_t face_of(input logic [3:0] code);
    logic [3:0] w_rel;
    w_rel = code - MV_R;
    return face_t'(w_rel[3:1]);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Circular move-code queue, DEPTH entries of 4 bits.
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   i_push, i_data    write request and code; ignored when full or flushing
//   i_pop             consume the head; ignored when empty or flushing
//   i_flush           synchronous clear; wins over push and pop
//   o_data            head entry (combinational read)
//   o_full, o_empty   occupancy flags
//   o_level           occupancy, 0..DEPTH
module move_fifo #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic [3:0]    i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [3:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  logic [3:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Queues solver move codes and issues them one at a time to the stepper
// sequencer, with pause/resume, flush, a settle gap between moves and
// progress/error reporting.
// Handshake: a push is accepted on a clock where push_valid && push_ready.
// A move is issued with a one-cycle move_start while next_move holds the code;
// the stepper acknowledges by dropping move_done and finishes by raising it.
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   push_valid/move/ready   solver push interface
//   run, flush              execute/pause control, queue + error-flag clear
//   next_move, move_start   issue interface; move_done from the steppers
//   busy, level             not-IDLE flag, queue occupancy
//   moves_completed         saturating count of acknowledged moves
//   no_ack_err/bad_code_err sticky error flags
//   dbg_state               current FSM state
module move_sequencer
  import move_codes_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int GAP_CYCLES  = 250000,
  parameter int ACK_TIMEOUT = 16,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_valid,
  input  logic [3:0]    push_move,
  output logic          push_ready,
  input  logic          run,
  input  logic          flush,
  output logic [3:0]    next_move,
  output logic          move_start,
  input  logic          move_done,
  output logic          busy,
  output logic [LW-1:0] level,
  output logic [15:0]   moves_completed,
  output logic          no_ack_err,
  output logic          bad_code_err,
  output seq_state_t    dbg_state
);

  localparam int TMAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;

  seq_state_t     r_state;
  seq_state_t     w_next_state;
  logic [TW-1:0]  r_timer;
  logic [TW-1:0]  w_timer_next;
  logic [3:0]     r_next_move;
  logic [15:0]    r_moves_completed;
  logic           r_no_ack_err;
  logic           r_bad_code_err;
  logic           w_pop;
  logic           w_load;
  logic           w_set_bad;
  logic           w_set_noack;
  logic           w_count;
  logic [3:0]     w_head;
  logic           w_full;
  logic           w_empty;

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (push_valid),
    .i_data  (push_move),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign push_ready      = !w_full;
  assign next_move       = r_next_move;
  assign move_start      = (r_state == ST_ISSUE);
  assign busy            = (r_state != ST_IDLE);
  assign moves_completed = r_moves_completed;
  assign no_ack_err      = r_no_ack_err;
  assign bad_code_err    = r_bad_code_err;
  assign dbg_state       = r_state;

  // One timer serves both the ack timeout and the settle gap; it is zeroed
  // on every transition into a timed state.
  always_comb begin
    w_next_state = r_state;
    w_timer_next = r_timer;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_set_bad    = 1'b0;
    w_set_noack  = 1'b0;
    w_count      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // No pop while flushing: the head is being discarded this cycle.
        if (run && !w_empty && !flush) begin
          w_pop = 1'b1;
          if (is_legal_move(w_head)) begin
            w_load       = 1'b1;
            w_next_state = ST_ISSUE;
          end else if (!is_nop(w_head)) begin
            w_set_bad = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        w_timer_next = '0;
        w_next_state = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!move_done) begin
          w_next_state = ST_WAIT_DONE;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
          // Steppers never started (e.g. disabled): skip without counting.
          w_set_noack  = 1'b1;
          w_timer_next = '0;
          w_next_state = ST_GAP;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (move_done) begin
          w_count      = 1'b1;
          w_timer_next = '0;
          w_next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_timer == TW'(GAP_CYCLES - 1)) begin
          w_timer_next = '0;
          w_next_state = ST_IDLE;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_timer           <= '0;
      r_next_move       <= '0;
      r_moves_completed <= '0;
      r_no_ack_err      <= 1'b0;
      r_bad_code_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_timer <= w_timer_next;
      if (w_load) r_next_move <= w_head;
      if (w_count && (r_moves_completed != 16'hFFFF))
        r_moves_completed <= r_moves_completed + 16'd1;
      // A timeout from a move still in flight during a flush is reported.
      if (w_set_noack)   r_no_ack_err <= 1'b1;
      else if (flush)    r_no_ack_err <= 1'b0;
      if (w_set_bad)     r_bad_code_err <= 1'b1;
      else if (flush)    r_bad_code_err <= 1'b0;
    end
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Queues a solution string of 4-bit move codes from the solver and issues them one at a time to the stepper sequencer (next_move / move_start / move_done handshake). It pauses and resumes on command, flushes on request and enforces a settle gap between moves. It also reports progress: queue level, completed-move count and sticky error flags.

Parameters:
DEPTH, 64, queue entries; power of two, at least 2.
GAP_CYCLES, 250000, idle clocks after move_done before the next issue; at least 1.
ACK_TIMEOUT, 16, clocks to wait for move_done to fall after move_start; at least 2.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
push_valid  input  1  solver offers push_move this cycle
push_move  input  4  move code (2..13 valid; 0/1 no-op; 14/15 illegal)
push_ready  output  1  queue not full; a push is accepted when push_valid && push_ready
run  input  1  1 = execute queue; 0 = pause after the in-flight move
flush  input  1  synchronous clear of queue contents and of error flags
next_move  output  4  registered code presented to the stepper sequencer
move_start  output  1  one-cycle issue pulse
move_done  input  1  high when all stepper drivers are idle
busy  output  1  high in any state other than IDLE
level  output  clog2(DEPTH)+1  current queue occupancy
moves_completed  output  16  count of moves finished; saturates at 16'hFFFF
no_ack_err  output  1  sticky: move_done never fell within ACK_TIMEOUT
bad_code_err  output  1  sticky: code 14 or 15 was dequeued

Behaviour:
- Asynchronous reset clears every output to 0 except push_ready, which resets to 1. Queue empties, state goes to IDLE, counters clear. moves_completed clears only on reset.
- Queue is a circular buffer with wrapping pointers. Push and pop in the same cycle are legal when not full. level stays unchanged in that case.
- A push while full is impossible, because push_ready is low.
- flush has priority over push in the same cycle: the push is dropped. flush empties the queue and clears both error flags. An in-flight move is not aborted and completes its handshake normally.
- States:
 - IDLE: if run && level!=0, pop the head.
   - Code 2..13: load next_move, go to ISSUE.
   - Code 0/1: discard, stay in IDLE. At most one pop per cycle.
   - Code 14/15: discard, set bad_code_err, stay in IDLE.
 - ISSUE: move_start=1 for exactly this cycle, ack timer cleared, go to WAIT_ACK.
 - WAIT_ACK: if move_done==0, go to WAIT_DONE.
   - Otherwise, when the timer reaches ACK_TIMEOUT-1, set no_ack_err and go to GAP without counting the move. This covers the case where disabled steppers never start.
 - WAIT_DONE: when move_done==1, increment moves_completed and go to GAP.
 - GAP: count GAP_CYCLES clocks, then return to IDLE.
- next_move holds its value from ISSUE until the next load; move_start is never asserted outside ISSUE.
- Latency: a push into an empty queue with run=1 produces move_start 2 clocks after the push cycle (registered queue write, then pop in IDLE).
- Dropping run mid-move has no effect until IDLE; the sequencer then holds with queue intact. Raising run resumes with the next queued move.
- Reset mid-move returns to IDLE immediately; no move_start is ever reissued for the lost move.

Decomposition:
- Shared package move_codes_pkg:
 - Move-code constants R=2 through Di=13.
 - NOP codes 0/1.
 - Face indices RIGHT..DOWN.
 - Helper predicate is_legal_move(code).
 - The stepper sequencer and the solver use the same package.
- One sub-module, move_fifo: parameterised DEPTH × 4-bit circular buffer with push/pop/flush/level. The FSM, timers and counters stay in move_sequencer.

Test Plan:
- Reset, then push R(2), U'(5) with run=1; model move_done falling 3 clocks after each pulse and rising 20 clocks later.
  - Required: move_start pulses with next_move=2 then 5, separated by ≥GAP_CYCLES plus handshake time.
  - Required: moves_completed=2, level=0, busy=0 at the end.
- Push 0, 1, F(6).
  - Required: exactly one move_start, with next_move=6; moves_completed=1.
  - Push 15 instead: bad_code_err=1 and no issue.
- Hold move_done=1 permanently and push L(8).
  - Required: move_start once, no_ack_err=1 after 16 clocks.
  - Required: moves_completed=0 and the queue continues to the next entry.
- Fill with DEPTH pushes under run=0.
  - Required: push_ready=0 and level=64.
  - Then push_valid with flush in the same cycle: required level=0, push_ready=1, no move_start.
- Drop run during WAIT_DONE.
  - Required: the in-flight move completes and is counted, then the block holds in IDLE.
  - Re-raise run: required that the next code issues.
- Assert reset during WAIT_DONE: required that all outputs return to reset values asynchronously and there is no move_start after release.
